sqrt_pipe_arbiter: RTL

- Shares one fixed-latency pipelined integer square-root unit (isqrt) among N_REQ requesters.
- Each cycle, a round-robin arbiter issues at most one argument into the unit.
- A tag delay line, matched to the unit's latency, carries the requester id so each result returns to its originator.
- Sits between the formula pipelines (the requesters) and a single isqrt instance.

---
 rtl/sqrt_pipe_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sqrt_pipe_arbiter.sv
// ============================================================================
// Module   : sqrt_pipe_arbiter
// Purpose  : Round-robin sharing of one fixed-latency pipelined isqrt unit
//            among N_REQ requesters, with a tag line routing results home.
//            Optional macro SQRT_PIPE_ARBITER_ERR_CHECK_EN enables the sticky
//            err flag on tag/result valid mismatches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_pipe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ*WIDTH-1:0]        req_x,
    output logic [N_REQ-1:0]              req_rdy,
    output logic [N_REQ-1:0]              res_vld,
    output logic [WIDTH-1:0]              res_y,
    output logic                          sqrt_x_vld,
    output logic [WIDTH-1:0]              sqrt_x,
    input  logic                          sqrt_y_vld,
    input  logic [WIDTH-1:0]              sqrt_y,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic                          err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [IW-1:0] C_PTR_RST = IW'(N_REQ - 1);

    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_gidx;
    logic [N_REQ-1:0] w_grant;
    logic             w_issue;
    logic [LATENCY-1:0] r_tag_vld;
    logic [IW-1:0]    r_tag_id [LATENCY];
    logic             w_ret;
    logic [N_REQ-1:0] r_res_vld;
    logic [WIDTH-1:0] r_res_y;
    logic [CW-1:0]    r_inflight;

    // Scan starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        w_grant = '0;
        w_gidx  = r_ptr;
        w_issue = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_issue && req_vld[idx] && rst_n) begin
                w_issue      = 1'b1;
                w_grant[idx] = 1'b1;
                w_gidx       = IW'(idx);
            end
        end
    end

    assign req_rdy    = w_grant;
    assign sqrt_x_vld = w_issue;
    assign sqrt_x     = w_issue ? req_x[int'(w_gidx)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= C_PTR_RST;
        end else if (w_issue) begin
            r_ptr <= w_gidx;
        end
    end

    // Tag line shifts unconditionally to mirror the non-stalling isqrt pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int s = 0; s < LATENCY; s++) r_tag_id[s] <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_gidx;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign w_ret = sqrt_y_vld & r_tag_vld[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_vld  <= '0;
            r_res_y    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_ret) begin
                r_res_vld <= N_REQ'(1) << r_tag_id[LATENCY-1];
                r_res_y   <= sqrt_y;
            end else begin
                r_res_vld <= '0;
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(|r_res_vld);
        end
    end

    assign res_vld  = r_res_vld;
    assign res_y    = r_res_y;
    assign inflight = r_inflight;

`ifdef SQRT_PIPE_ARBITER_ERR_CHECK_EN
    logic r_err;
    logic w_mismatch;

    assign w_mismatch = sqrt_y_vld ^ r_tag_vld[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

`ifndef SYNTHESIS
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_mismatch) begin
                if (sqrt_y_vld)
                    $error("sqrt_pipe_arbiter: cycle %0d: sqrt_y_vld without valid tag", r_cycle);
                else
                    $error("sqrt_pipe_arbiter: cycle %0d: valid tag without sqrt_y_vld", r_cycle);
            end
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire
